// File: rtl/myfilter_pkg.sv
// Shared types and widths for the FIR filter datapath.
// Provides sample/accumulator widths, ALU commands and sequencer states.
package myfilter_pkg;

    localparam int DATABITS = 16;
    localparam int ACCBITS  = 40;

    typedef enum logic [1:0] {
        ALU_NOP,
        ALU_MU,
        ALU_ADMU,
        ALU_SATA
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT,
        OUT
    } ctrl_state_t;

endpackage

// File: rtl/myfilter_ctrl_svamod.sv
// Protocol and X checker bound into every myfilter_ctrl instance.
// Ports: observes all myfilter_ctrl outputs plus clk/rst_n/dout_ready.
module myfilter_ctrl_svamod
    import myfilter_pkg::*;
#(
    parameter int AW = 3
) (
    input logic                clk,
    input logic                rst_n,
    input logic                din_ready,
    input logic [DATABITS-1:0] dout,
    input logic                dout_valid,
    input logic                dout_ready,
    input logic [AW-1:0]       coeff_addr,
    input alu_cmd_t            cmd_out,
    input logic [DATABITS-1:0] m1_out,
    input logic [DATABITS-1:0] m2_out,
    input logic [ACCBITS-1:0]  acc_out
);

    a_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({din_ready, dout, dout_valid, coeff_addr,
                     cmd_out, m1_out, m2_out, acc_out}));

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (dout_valid && !dout_ready) |=> (dout_valid && $stable(dout)));

    a_idle: assert property (@(posedge clk) disable iff (!rst_n)
        din_ready |-> (!dout_valid && cmd_out == ALU_NOP));

endmodule

bind myfilter_ctrl myfilter_ctrl_svamod #(
    .AW (AW)
) u_svamod (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .coeff_addr (coeff_addr),
    .cmd_out    (cmd_out),
    .m1_out     (m1_out),
    .m2_out     (m2_out),
    .acc_out    (acc_out)
);

// File: rtl/myfilter_dline.sv
// Circular sample delay line with a tap-offset read port.
// Ports: i_we/i_wdata write at wptr; i_off selects sample (newest = 0).
module myfilter_dline
    import myfilter_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [DATABITS-1:0] i_wdata,
    input  logic [AW-1:0]       i_off,
    output logic [DATABITS-1:0] o_rdata
);

    localparam int IW = AW + 1;

    logic [DATABITS-1:0] r_mem [TAPS];
    logic [AW-1:0]       r_wptr;
    logic [IW-1:0]       w_sum;
    logic [IW-1:0]       w_idx;

    // wptr-1-off folded into [0, 2*TAPS-2]; one conditional
    // subtraction brings it back into range for any TAPS.
    always_comb begin
        w_sum = IW'(r_wptr) + IW'(TAPS - 1) - IW'(i_off);
        w_idx = w_sum;
        if (w_sum >= IW'(TAPS)) begin
            w_idx = w_sum - IW'(TAPS);
        end
    end

    assign o_rdata = r_mem[w_idx[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[r_wptr] <= i_wdata;
            if (r_wptr == AW'(TAPS - 1)) begin
                r_wptr <= '0;
            end else begin
                r_wptr <= r_wptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/myfilter_ctrl.sv
// FIR sequencer: accepts a sample, issues MU/ADMU per tap then SATA.
// Ports: din/dout valid-ready streams, coeff ROM port, ALU command port.
module myfilter_ctrl
    import myfilter_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATABITS-1:0] din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic signed [DATABITS-1:0] dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [AW-1:0]              coeff_addr,
    input  logic signed [DATABITS-1:0] coeff_in,
    output alu_cmd_t                   cmd_out,
    output logic signed [DATABITS-1:0] m1_out,
    output logic signed [DATABITS-1:0] m2_out,
    output logic [ACCBITS-1:0]         acc_out,
    input  logic [ACCBITS-1:0]         alu_in
);

    ctrl_state_t         r_state;
    ctrl_state_t         w_next;
    logic [AW-1:0]       r_k;
    logic [ACCBITS-1:0]  r_acc;
    logic [DATABITS-1:0] r_dout;
    logic                r_dout_valid;
    logic                w_accept;
    logic [DATABITS-1:0] w_tap;

    myfilter_dline #(
        .TAPS (TAPS),
        .AW   (AW)
    ) u_dline (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_accept),
        .i_wdata (din),
        .i_off   (r_k),
        .o_rdata (w_tap)
    );

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        din_ready  = 1'b0;
        cmd_out    = ALU_NOP;
        m1_out     = '0;
        m2_out     = '0;
        coeff_addr = '0;
        unique case (r_state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    w_accept = 1'b1;
                    w_next   = MAC;
                end
            end
            MAC: begin
                coeff_addr = r_k;
                m1_out     = w_tap;
                m2_out     = coeff_in;
                cmd_out    = (r_k == '0) ? ALU_MU : ALU_ADMU;
                if (r_k == AW'(TAPS - 1)) begin
                    w_next = SAT;
                end
            end
            SAT: begin
                cmd_out = ALU_SATA;
                w_next  = OUT;
            end
            OUT: begin
                if (dout_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_k <= '0;
                    end
                end
                MAC: begin
                    r_acc <= alu_in;
                    r_k   <= r_k + 1'b1;
                end
                SAT: begin
                    r_dout       <= alu_in[DATABITS-1:0];
                    r_dout_valid <= 1'b1;
                end
                OUT: begin
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_out    = r_acc;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_myfilter_ctrl.sv
// Self-checking bench for myfilter_ctrl with a behavioural Q15 ALU.
// Reference: direct FIR sum over a sample history, round, saturate.
module tb_myfilter_ctrl;
    import myfilter_pkg::*;

    localparam int TAPS = 4;
    localparam int AW   = 2;

    logic                       clk;
    logic                       rst_n;
    logic signed [DATABITS-1:0] din;
    logic                       din_valid;
    logic                       din_ready;
    logic signed [DATABITS-1:0] dout;
    logic                       dout_valid;
    logic                       dout_ready;
    logic [AW-1:0]              coeff_addr;
    logic signed [DATABITS-1:0] coeff_in;
    alu_cmd_t                   cmd_out;
    logic signed [DATABITS-1:0] m1_out;
    logic signed [DATABITS-1:0] m2_out;
    logic [ACCBITS-1:0]         acc_out;
    logic [ACCBITS-1:0]         alu_in;

    int checks = 0;
    int errors = 0;

    logic signed [DATABITS-1:0] coef [TAPS];
    longint                     hist [TAPS];

    myfilter_ctrl #(
        .TAPS (TAPS),
        .AW   (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .coeff_addr (coeff_addr),
        .coeff_in   (coeff_in),
        .cmd_out    (cmd_out),
        .m1_out     (m1_out),
        .m2_out     (m2_out),
        .acc_out    (acc_out),
        .alu_in     (alu_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign coeff_in = coef[coeff_addr];

    // Behavioural ALU: Q15 x Q15 products, round-half-up, saturate.
    logic signed [ACCBITS-1:0]  prod;
    logic signed [ACCBITS-1:0]  rnd;
    logic signed [DATABITS-1:0] sat;
    always_comb begin
        prod = $signed(m1_out) * $signed(m2_out);
        rnd  = ($signed(acc_out) + 40'sd16384) >>> 15;
        if (rnd > 40'sd32767) begin
            sat = 16'sh7fff;
        end else if (rnd < -40'sd32768) begin
            sat = 16'sh8000;
        end else begin
            sat = rnd[DATABITS-1:0];
        end
        unique case (cmd_out)
            ALU_MU:   alu_in = prod;
            ALU_ADMU: alu_in = $signed(acc_out) + prod;
            ALU_SATA: alu_in = {{(ACCBITS-DATABITS){sat[DATABITS-1]}}, sat};
            default:  alu_in = acc_out;
        endcase
    end

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
    endfunction

    function automatic void model_push(input logic signed [15:0] x);
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = longint'(x);
    endfunction

    function automatic logic [15:0] model_out();
        longint s;
        longint r;
        s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(coef[i]) * hist[i];
        r = (s + 16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic apply_reset();
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        din        = '0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_coefs(input logic [15:0] c);
        for (int i = 0; i < TAPS; i++) coef[i] = c;
    endtask

    task automatic run_sample(input logic [15:0] x, input int bp,
                              output logic [15:0] got);
        int          n;
        logic [15:0] exp;
        logic [15:0] held;
        alu_cmd_t    ecmd;
        n = 0;
        while (!din_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b want 1", din_ready);
        end
        din       = x;
        din_valid = 1'b1;
        @(posedge clk);
        model_push(x);
        exp = model_out();
        @(negedge clk);
        din_valid = 1'b0;
        din       = 16'($urandom);
        for (int k = 0; k < TAPS; k++) begin
            if (k > 0) @(negedge clk);
            ecmd = (k == 0) ? ALU_MU : ALU_ADMU;
            checks++;
            if (cmd_out !== ecmd || coeff_addr !== AW'(k)) begin
                errors++;
                $display("FAIL mac_cmd k=%0d: got cmd %0d addr %0d want cmd %0d addr %0d",
                         k, cmd_out, coeff_addr, ecmd, k);
            end
            checks++;
            if (m1_out !== 16'(hist[k]) || m2_out !== coef[k]) begin
                errors++;
                $display("FAIL mac_ops k=%0d: got m1 %h m2 %h want m1 %h m2 %h",
                         k, m1_out, m2_out, 16'(hist[k]), coef[k]);
            end
            checks++;
            if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL mac_busy k=%0d: got ready %b valid %b want 0 0",
                         k, din_ready, dout_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (cmd_out !== ALU_SATA || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_cycle: got cmd %0d valid %b want cmd %0d valid 0",
                     cmd_out, dout_valid, ALU_SATA);
        end
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || dout !== exp) begin
            errors++;
            $display("FAIL dout: got valid %b data %h want valid 1 data %h",
                     dout_valid, dout, exp);
        end
        got        = dout;
        held       = dout;
        dout_ready = (bp == 0);
        din_valid  = (bp > 0);
        din        = 16'($urandom);
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            checks++;
            if (dout !== held || dout_valid !== 1'b1 ||
                din_ready !== 1'b0 || cmd_out !== ALU_NOP) begin
                errors++;
                $display("FAIL backpressure b=%0d: got data %h valid %b ready %b cmd %0d want %h 1 0 0",
                         b, dout, dout_valid, din_ready, cmd_out, held);
            end
        end
        dout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1 || cmd_out !== ALU_NOP) begin
            errors++;
            $display("FAIL handshake: got valid %b ready %b cmd %0d want 0 1 0",
                     dout_valid, din_ready, cmd_out);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0 || cmd_out !== ALU_NOP) begin
            errors++;
            $display("FAIL reset_ctl: got ready %b valid %b cmd %0d want 1 0 0",
                     din_ready, dout_valid, cmd_out);
        end
        checks++;
        if (dout !== '0 || acc_out !== '0 || coeff_addr !== '0 ||
            m1_out !== '0 || m2_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got dout %h acc %h addr %0d m1 %h m2 %h want all 0",
                     dout, acc_out, coeff_addr, m1_out, m2_out);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] ins [5]  = '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] outs [5] = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h0};
        logic [15:0] got;
        apply_reset();
        set_coefs(16'h4000);
        for (int i = 0; i < 5; i++) begin
            run_sample(ins[i], 0, got);
            checks++;
            if (got !== outs[i]) begin
                errors++;
                $display("FAIL impulse[%0d]: got %h want %h", i, got, outs[i]);
            end
        end
    endtask

    task automatic test_step();
        logic [15:0] outs [4] = '{16'h2000, 16'h4000, 16'h6000, 16'h7fff};
        logic [15:0] got;
        apply_reset();
        set_coefs(16'h4000);
        for (int i = 0; i < 4; i++) begin
            run_sample(16'h4000, 0, got);
            checks++;
            if (got !== outs[i]) begin
                errors++;
                $display("FAIL step[%0d]: got %h want %h", i, got, outs[i]);
            end
        end
    endtask

    task automatic test_neg_sat();
        logic [15:0] got;
        apply_reset();
        set_coefs(16'h7fff);
        for (int i = 0; i < 4; i++) run_sample(16'h8000, 0, got);
        checks++;
        if (got !== 16'h8000) begin
            errors++;
            $display("FAIL neg_sat: got %h want 8000", got);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got;
        apply_reset();
        set_coefs(16'h4000);
        run_sample(16'h1234, 4, got);
        run_sample(16'h4000, 4, got);
    endtask

    task automatic test_reset_mid_mac();
        logic [15:0] got;
        apply_reset();
        set_coefs(16'h4000);
        run_sample(16'h3000, 0, got);
        run_sample(16'h5000, 0, got);
        din       = 16'h7000;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (coeff_addr !== 2'd2 || cmd_out !== ALU_ADMU) begin
            errors++;
            $display("FAIL mid_mac_pos: got addr %0d cmd %0d want 2 %0d",
                     coeff_addr, cmd_out, ALU_ADMU);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_out !== ALU_NOP || coeff_addr !== '0 || m1_out !== '0 ||
            m2_out !== '0 || acc_out !== '0 || dout !== '0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_mac_rst: got cmd %0d addr %0d m1 %h m2 %h acc %h dout %h valid %b want all 0",
                     cmd_out, coeff_addr, m1_out, m2_out, acc_out, dout, dout_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_sample(16'h4000, 0, got);
        checks++;
        if (got !== 16'h2000) begin
            errors++;
            $display("FAIL post_rst: got %h want 2000", got);
        end
    endtask

    task automatic test_random();
        logic [15:0] got;
        apply_reset();
        for (int i = 0; i < TAPS; i++) coef[i] = 16'($urandom);
        for (int s = 0; s < 16; s++) begin
            run_sample(16'($urandom), int'($urandom_range(0, 2)), got);
        end
        for (int i = 0; i < TAPS; i++) coef[i] = 16'($urandom_range(0, 16'h1fff));
        for (int s = 0; s < 8; s++) begin
            run_sample(16'($urandom), 0, got);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        set_coefs(16'h0);
        model_reset();
        test_reset();
        test_impulse();
        test_step();
        test_neg_sat();
        test_backpressure();
        test_reset_mid_mac();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/myfilter_ctrl.md
# myfilter_ctrl

FIR sequencer that drives the filter ALU: it is the command issuer on the ALU's `cmd_in` / `m1_in` / `m2_in` / `acc_in` interface, and the consumer of its `d_out`. It accepts one input sample per valid/ready handshake and stores it in a circular delay line. It then issues one multiply or multiply-accumulate command per tap, followed by a saturating round (`ALU_SATA`). The saturated result is presented on a valid/ready output port.

## Interface
Parameters:
- `TAPS`, default 8: filter length, ≥2.
- `AW`, default `$clog2(TAPS)`: coefficient address width.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `din`, in, `DATABITS`: input sample, signed.
- `din_valid`, in, 1: input sample valid.
- `din_ready`, out, 1: block can accept a sample.
- `dout`, out, `DATABITS`: filtered output, signed.
- `dout_valid`, out, 1: output valid.
- `dout_ready`, in, 1: downstream accepts `dout`.
- `coeff_addr`, out, `AW`: tap index k.
- `coeff_in`, in, `DATABITS`: coefficient c[k]. Combinational, valid in the same cycle as `coeff_addr`.
- `cmd_out`, out, `alu_cmd_t`: ALU command, to ALU `cmd_in`.
- `m1_out`, out, `DATABITS`: ALU operand 1 (sample).
- `m2_out`, out, `DATABITS`: ALU operand 2 (coefficient).
- `acc_out`, out, `ACCBITS`: accumulator register, to ALU `acc_in`.
- `alu_in`, in, `ACCBITS`: ALU result `d_out`. Combinational, same cycle.

## Operation
- FSM states: `IDLE`, `MAC`, `SAT`, `OUT`.
- `IDLE`:
  - `din_ready`=1.
  - On `din_valid && din_ready`: write `din` to `dline[wptr]`, `wptr<=wptr+1` (mod `TAPS`), `k<=0`, go to `MAC`.
- `MAC` (k = 0..TAPS-1):
  - `m1_out` = `dline[(wptr_new-1-k) mod TAPS]` (newest sample first).
  - `coeff_addr`=k, `m2_out`=`coeff_in`.
  - `cmd_out` = `ALU_MU` for k=0, `ALU_ADMU` for k>0.
  - Each cycle `acc<=alu_in`.
  - At k=TAPS-1 go to `SAT`.
- `SAT`:
  - `cmd_out`=`ALU_SATA`, `acc_out`=acc.
  - `dout<=alu_in[DATABITS-1:0]`, `dout_valid<=1`, go to `OUT`.
- `OUT`:
  - Hold `dout` and `dout_valid` stable until `dout_ready`.
  - On `dout_valid && dout_ready`: `dout_valid<=0`, go to `IDLE`.
- `din_ready`=0 in `MAC`, `SAT` and `OUT`. No overlap between samples.
- Outside `MAC`/`SAT`: `cmd_out`=`ALU_NOP`, `m1_out`=`m2_out`=0, `coeff_addr`=0.
- Arithmetic (multiply, accumulate, saturate, round) is done entirely by the ALU. The block only routes data and registers `acc` and `dout`.
- Wrap-around: `wptr` and the read index wrap modulo `TAPS`. This is correct for non-power-of-2 `TAPS`.
- Reset (asynchronous, including mid-`MAC`/`SAT`/`OUT`):
  - State → `IDLE`; `wptr`, `k`, `acc`, `dout`, `dout_valid` → 0.
  - All `dline` entries → 0.
  - `cmd_out`=`ALU_NOP`. `din_ready` reads 1 once `rst_n` is high.
  - An in-flight sample is discarded; no partial output is ever emitted.

## Timing
- Accept at edge E0.
- `MAC` occupies cycles E0..E0+TAPS-1; `SAT` is cycle E0+TAPS.
- `dout_valid` is high from edge E0+TAPS+1. Latency is `TAPS`+1 cycles from accept to valid.
- Throughput is at best one sample per `TAPS`+3 cycles (accept, `TAPS` MAC, `SAT`, output handshake).
- Outputs `cmd_out`, `m1_out`, `m2_out`, `coeff_addr` are decoded from registered state. `acc_out`, `dout` and `dout_valid` are registers.
- `din_valid` arriving while busy is ignored (not lost: the producer holds it per the handshake).
- `din_valid` asserted in the same cycle as `OUT` completes is not accepted until the next cycle (in `IDLE`).

## Structure
- `myfilter_pkg` provides `DATABITS`, `ACCBITS` and `alu_cmd_t`.
- Add to `myfilter_pkg`: typedef `ctrl_state_t` (`IDLE`, `MAC`, `SAT`, `OUT`).
- Sub-module `myfilter_dline`:
  - Circular sample buffer with write port, `wptr`, and a combinational read port indexed by tap offset.
  - Asynchronous clear.
- A matching `myfilter_ctrl_svamod` checker binds alongside, with X-checks on all outputs.

## Test plan
Settings for all scenarios: `TAPS`=4, `DATABITS`=16, ALU instance connected.
- Impulse: all coeffs 0x4000; input 0x4000, then 0x0000 ×4.
  - Outputs 0x2000, 0x2000, 0x2000, 0x2000, 0x0000.
  - `cmd_out` sequence per sample is MU, ADMU, ADMU, ADMU, SATA.
- Step: all coeffs 0x4000; input 0x4000 ×4.
  - Outputs 0x2000, 0x4000, 0x6000, 0x7FFF (the last saturates positive).
- Negative saturation: coeffs 0x7FFF; input 0x8000 ×4.
  - Fourth output is 0x8000.
- Backpressure: hold `dout_ready`=0 for 5 cycles after `dout_valid`.
  - `dout` stable, `din_ready`=0 and `cmd_out`=`ALU_NOP` throughout.
  - Accepted on the 6th cycle.
- Reset mid-`MAC` (k=2): all outputs return to reset values immediately.
  - The next input 0x4000 with coeffs 0x4000 yields 0x2000 (history cleared).
- Latency: accept at edge N.
  - `dout_valid` rises at edge N+5.
  - `din_ready` reasserts the cycle after the output handshake.
